// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register: captures decoded operands and control, forwards
// from EX/MEM and MEM/WB, and inserts a bubble on a load-use hazard.
module id_ex_operand_stage #(
   parameter int WIDTH = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [RADDR-1:0] in_rs,
   input  logic [RADDR-1:0] in_rt,
   input  logic [RADDR-1:0] in_rd,
   input  logic [WIDTH-1:0] in_rs_val,
   input  logic [WIDTH-1:0] in_rt_val,
   input  logic [15:0]      in_imm,
   input  logic             in_alusrc,
   input  logic             in_signext,
   input  logic [2:0]       in_aluop,
   input  logic             in_regwrite,
   input  logic             in_memread,
   input  logic             in_memwrite,
   input  logic             stall,
   input  logic             flush,
   input  logic             exmem_regwrite,
   input  logic [RADDR-1:0] exmem_rd,
   input  logic [WIDTH-1:0] exmem_result,
   input  logic             memwb_regwrite,
   input  logic [RADDR-1:0] memwb_rd,
   input  logic [WIDTH-1:0] memwb_result,
   output logic             out_valid,
   output logic [WIDTH-1:0] data1,
   output logic [WIDTH-1:0] data2,
   output logic [2:0]       ALUOp,
   output logic [RADDR-1:0] out_rd,
   output logic             out_regwrite,
   output logic             out_memread,
   output logic             out_memwrite,
   output logic [WIDTH-1:0] out_store_data,
   output logic             hazard_stall
);

   logic             v_q;
   logic [RADDR-1:0] rs_q, rt_q, rd_q;
   logic [WIDTH-1:0] rsval_q, rtval_q;
   logic [15:0]      imm_q;
   logic             alusrc_q, signext_q;
   logic [2:0]       aluop_q;
   logic             regwrite_q, memread_q, memwrite_q;

   logic [WIDTH-1:0] ext;
   logic [WIDTH-1:0] fwd_rs, fwd_rt;
   logic             rs_dep, rt_dep;

   // A held load whose destination feeds the incoming instruction cannot be forwarded in time.
   always_comb begin
      rs_dep       = (rd_q == in_rs);
      rt_dep       = (rd_q == in_rt) & ~in_alusrc;
      hazard_stall = ~flush & in_valid & v_q & memread_q & (rd_q != '0) & (rs_dep | rt_dep);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q        <= 1'b0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         rsval_q    <= '0;
         rtval_q    <= '0;
         imm_q      <= '0;
         alusrc_q   <= 1'b0;
         signext_q  <= 1'b0;
         aluop_q    <= '0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end else if (flush || (!stall && hazard_stall)) begin
         // Flush and bubble both only kill valid and control; datapath fields are don't-care.
         v_q        <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end else if (!stall) begin
         v_q        <= in_valid;
         rs_q       <= in_rs;
         rt_q       <= in_rt;
         rd_q       <= in_rd;
         rsval_q    <= in_rs_val;
         rtval_q    <= in_rt_val;
         imm_q      <= in_imm;
         alusrc_q   <= in_alusrc;
         signext_q  <= in_signext;
         aluop_q    <= in_aluop;
         regwrite_q <= in_valid & in_regwrite;
         memread_q  <= in_valid & in_memread;
         memwrite_q <= in_valid & in_memwrite;
      end
   end

   always_comb begin
      if (signext_q) ext = {{(WIDTH-16){imm_q[15]}}, imm_q};
      else           ext = {{(WIDTH-16){1'b0}}, imm_q};
   end

   // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
   always_comb begin
      fwd_rs = rsval_q;
      if (rs_q != '0 && exmem_regwrite && exmem_rd == rs_q)
         fwd_rs = exmem_result;
      else if (rs_q != '0 && memwb_regwrite && memwb_rd == rs_q)
         fwd_rs = memwb_result;
   end

   always_comb begin
      fwd_rt = rtval_q;
      if (rt_q != '0 && exmem_regwrite && exmem_rd == rt_q)
         fwd_rt = exmem_result;
      else if (rt_q != '0 && memwb_regwrite && memwb_rd == rt_q)
         fwd_rt = memwb_result;
   end

   assign out_valid      = v_q;
   assign data1          = fwd_rs;
   assign data2          = alusrc_q ? ext : fwd_rt;
   assign out_store_data = fwd_rt;
   assign ALUOp          = aluop_q;
   assign out_rd         = rd_q;
   assign out_regwrite   = regwrite_q;
   assign out_memread    = memread_q;
   assign out_memwrite   = memwrite_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed literal cases plus
// randomized traffic compared every cycle against a slot-level model.
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [31:0] in_rs_val, in_rt_val;
   logic [15:0] in_imm;
   logic        in_alusrc, in_signext;
   logic [2:0]  in_aluop;
   logic        in_regwrite, in_memread, in_memwrite;
   logic        stall, flush;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        out_valid;
   logic [31:0] data1, data2, out_store_data;
   logic [2:0]  ALUOp;
   logic [4:0]  out_rd;
   logic        out_regwrite, out_memread, out_memwrite;
   logic        hazard_stall;

   int errors = 0;
   int checks = 0;
   logic started = 1'b0;

   always #5 clk = ~clk;

   id_ex_operand_stage #(.WIDTH(32), .RADDR(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_alusrc(in_alusrc), .in_signext(in_signext), .in_aluop(in_aluop),
      .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
      .stall(stall), .flush(flush),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .out_valid(out_valid), .data1(data1), .data2(data2), .ALUOp(ALUOp),
      .out_rd(out_rd), .out_regwrite(out_regwrite), .out_memread(out_memread),
      .out_memwrite(out_memwrite), .out_store_data(out_store_data),
      .hazard_stall(hazard_stall)
   );

   // Model: one instruction slot plus a flag saying whether its datapath is meaningful.
   typedef struct packed {
      logic        valid;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsv, rtv;
      logic [15:0] imm;
      logic        alusrc, signext;
      logic [2:0]  aluop;
      logic        rw, mr, mw;
   } slot_t;

   slot_t m;
   logic  m_dv;

   function automatic logic [31:0] f_fwd(input logic [4:0] idx, input logic [31:0] v);
      if (idx == 0) return v;
      if (exmem_regwrite && exmem_rd == idx) return exmem_result;
      if (memwb_regwrite && memwb_rd == idx) return memwb_result;
      return v;
   endfunction

   function automatic logic [31:0] f_ext(input logic [15:0] imm, input logic se);
      int signed s;
      if (!se) return {16'h0, imm};
      s = int'(signed'(imm));
      return 32'(s);
   endfunction

   function automatic logic f_hz();
      if (flush || !in_valid || !m.valid || !m.mr || m.rd == 0) return 1'b0;
      return (m.rd == in_rs) || (m.rd == in_rt && !in_alusrc);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         m    <= '0;
         m_dv <= 1'b1;
      end else if (flush || (!stall && f_hz())) begin
         m.valid <= 1'b0;
         m.rw    <= 1'b0;
         m.mr    <= 1'b0;
         m.mw    <= 1'b0;
         m_dv    <= 1'b0;
      end else if (!stall) begin
         m    <= '{in_valid, in_rs, in_rt, in_rd, in_rs_val, in_rt_val, in_imm,
                  in_alusrc, in_signext, in_aluop,
                  in_valid & in_regwrite, in_valid & in_memread, in_valid & in_memwrite};
         m_dv <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("out_valid", 32'(out_valid), 32'(m.valid));
         chk("out_regwrite", 32'(out_regwrite), 32'(m.rw));
         chk("out_memread", 32'(out_memread), 32'(m.mr));
         chk("out_memwrite", 32'(out_memwrite), 32'(m.mw));
         chk("hazard_stall", 32'(hazard_stall), 32'(f_hz()));
         if (m_dv) begin
            chk("data1", data1, f_fwd(m.rs, m.rsv));
            chk("data2", data2, m.alusrc ? f_ext(m.imm, m.signext) : f_fwd(m.rt, m.rtv));
            chk("store_data", out_store_data, f_fwd(m.rt, m.rtv));
            chk("ALUOp", 32'(ALUOp), 32'(m.aluop));
            chk("out_rd", 32'(out_rd), 32'(m.rd));
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0;
      in_rs_val = '0; in_rt_val = '0; in_imm = '0;
      in_alusrc = 1'b0; in_signext = 1'b0; in_aluop = '0;
      in_regwrite = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0;
      stall = 1'b0; flush = 1'b0;
      exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
      memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      in_valid = 1'b1; in_rs = 5'd2; in_rs_val = 32'h1234; in_aluop = 3'b110; in_regwrite = 1'b1;
      next();
      started = 1'b1;
      // Basic load is presented while the reset state is checked.
      rst_n = 1'b1;
      in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
      in_rs_val = 32'd5; in_rt_val = 32'd7; in_aluop = 3'b010; in_alusrc = 1'b0;
      in_regwrite = 1'b1;
      @(negedge clk);
      chk("lit_reset_valid", 32'(out_valid), 32'd0);
      chk("lit_reset_data1", data1, 32'd0);
      chk("lit_reset_aluop", 32'(ALUOp), 32'd0);
      chk("lit_reset_hazard", 32'(hazard_stall), 32'd0);

      next();
      in_imm = 16'hFFFC; in_signext = 1'b1; in_alusrc = 1'b1;
      @(negedge clk);
      chk("lit_basic_data1", data1, 32'd5);
      chk("lit_basic_data2", data2, 32'd7);
      chk("lit_basic_aluop", 32'(ALUOp), 32'd2);
      chk("lit_basic_valid", 32'(out_valid), 32'd1);

      next();
      in_signext = 1'b0;
      @(negedge clk);
      chk("lit_sext", data2, 32'hFFFF_FFFC);

      next();
      in_alusrc = 1'b0; in_rs = 5'd3; in_rs_val = 32'h33;
      @(negedge clk);
      chk("lit_zext", data2, 32'h0000_FFFC);

      next();
      exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'd100;
      memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'd200;
      in_rs = 5'd0; in_rs_val = 32'd0;
      @(negedge clk);
      chk("lit_fwd_exmem", data1, 32'd100);
      #1 exmem_regwrite = 1'b0;
      #1 chk("lit_fwd_memwb", data1, 32'd200);
      exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
      memwb_regwrite = 1'b0;

      next();
      @(negedge clk);
      chk("lit_fwd_r0", data1, 32'd0);

      next();
      exmem_regwrite = 1'b0;
      in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd4;
      in_memread = 1'b1; in_regwrite = 1'b1; in_alusrc = 1'b1;
      next();
      in_rs = 5'd4; in_rt = 5'd2; in_rd = 5'd5; in_memread = 1'b0;
      in_alusrc = 1'b0; in_rs_val = 32'd11;
      @(negedge clk);
      chk("lit_loaduse_hazard", 32'(hazard_stall), 32'd1);
      next();
      @(negedge clk);
      chk("lit_bubble_valid", 32'(out_valid), 32'd0);
      #1 memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h777;
      next();
      @(negedge clk);
      chk("lit_after_bubble_valid", 32'(out_valid), 32'd1);
      chk("lit_after_bubble_data1", data1, 32'h777);

      #1 memwb_regwrite = 1'b0;
      in_valid = 1'b1; in_rs = 5'd6; in_rt = 5'd0; in_rd = 5'd7;
      in_aluop = 3'b001; in_regwrite = 1'b1;
      next();
      stall = 1'b1; exmem_regwrite = 1'b1; exmem_rd = 5'd6; exmem_result = 32'hAAAA;
      in_aluop = 3'b111; in_rs = 5'd9;
      @(negedge clk);
      chk("lit_stall_fwd_a", data1, 32'hAAAA);
      chk("lit_stall_aluop", 32'(ALUOp), 32'd1);
      next();
      exmem_result = 32'hBBBB;
      @(negedge clk);
      chk("lit_stall_fwd_b", data1, 32'hBBBB);
      chk("lit_stall_valid", 32'(out_valid), 32'd1);
      next();
      flush = 1'b1;
      next();
      flush = 1'b0; stall = 1'b0; exmem_regwrite = 1'b0;
      @(negedge clk);
      chk("lit_flush_valid", 32'(out_valid), 32'd0);
      chk("lit_flush_regwrite", 32'(out_regwrite), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         next();
         rst_n          = ($urandom_range(0, 99) != 0);
         flush          = ($urandom_range(0, 19) == 0);
         stall          = ($urandom_range(0, 6) == 0);
         in_valid       = ($urandom_range(0, 4) != 0);
         in_rs          = 5'($urandom_range(0, 7));
         in_rt          = 5'($urandom_range(0, 7));
         in_rd          = 5'($urandom_range(0, 7));
         in_rs_val      = $urandom;
         in_rt_val      = $urandom;
         in_imm         = 16'($urandom);
         in_alusrc      = 1'($urandom);
         in_signext     = 1'($urandom);
         in_aluop       = 3'($urandom);
         in_regwrite    = 1'($urandom);
         in_memread     = ($urandom_range(0, 2) == 0);
         in_memwrite    = ($urandom_range(0, 3) == 0);
         exmem_regwrite = 1'($urandom);
         exmem_rd       = 5'($urandom_range(0, 7));
         exmem_result   = $urandom;
         memwb_regwrite = 1'($urandom);
         memwb_rd       = 5'($urandom_range(0, 7));
         memwb_result   = $urandom;
      end
      next();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that captures decoded operands and control, then drives the ALU's data1, data2 and ALUOp inputs.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts one bubble.
- Upstream is decode/register-file read; downstream is the ALU and the EX/MEM register.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  decode slot holds an instruction
- in_rs, in_rt, in_rd  in  RADDR  source/destination indices (in_rd already muxed rd/rt by decode)
- in_rs_val, in_rt_val  in  WIDTH  register-file read data
- in_imm  in  16  instruction immediate
- in_alusrc  in  1  1: data2 comes from the immediate; 0: data2 comes from rt
- in_signext  in  1  1: sign-extend immediate; 0: zero-extend
- in_aluop  in  3  ALU opcode (000 AND, 001 OR, 010 ADD, 110 SUB, 011 LUI, 111 SLT)
- in_regwrite, in_memread, in_memwrite  in  1  control bits
- stall  in  1  downstream hold
- flush  in  1  kill the held instruction (branch taken)
- exmem_regwrite  in  1, exmem_rd  in  RADDR, exmem_result  in  WIDTH  EX/MEM forward source
- memwb_regwrite  in  1, memwb_rd  in  RADDR, memwb_result  in  WIDTH  MEM/WB forward source
- out_valid  out  1  held instruction valid
- data1, data2  out  WIDTH  ALU operands (forwarded)
- ALUOp  out  3  registered in_aluop
- out_rd  out  RADDR; out_regwrite, out_memread, out_memwrite  out  1  registered control
- out_store_data  out  WIDTH  forwarded rt value for stores
- hazard_stall  out  1  upstream must hold PC/IF/ID this cycle

Behaviour:
- Reset (rst_n=0 at posedge): out_valid, all registered control, indices, values and immediate go to 0. Consequently ALUOp=000, data1=data2=out_store_data=0 and hazard_stall=0. Reset dominates all other inputs.
- Register-update priority per posedge: reset > flush > stall > hazard bubble > load.
  - flush: out_valid=0, out_regwrite=out_memread=out_memwrite=0; datapath fields don't-care.
  - stall (flush=0): every register holds.
  - hazard_stall=1 (no stall/flush): bubble loaded, i.e. valid and control bits cleared.
  - otherwise: load all in_* fields; out_valid=in_valid. When in_valid=0, control bits are loaded as 0.
- Latency: one cycle from capture to outputs. Forwarding is combinational on the registered indices, so it re-evaluates every cycle, including while stalled.
- Immediate extension: ext = in_signext ? sign-extend(imm) : zero-extend(imm), computed on the registered imm. For LUI (ALUOp 011), decode sets in_signext=0; the ALU performs the shift.
- Forwarding for source s (rs or rt), applied to registered value v:
  - If s != 0, exmem_regwrite=1 and exmem_rd==s: use exmem_result.
  - Else if s != 0, memwb_regwrite=1 and memwb_rd==s: use memwb_result.
  - Else: use v.
  - Index 0 is never forwarded. EX/MEM wins over MEM/WB when both match.
- Output mapping: data1 = fwd(rs); out_store_data = fwd(rt); data2 = out_alusrc ? ext : fwd(rt).
- hazard_stall = out_valid & out_memread & (out_rd != 0) & (out_rd == in_rs | (out_rd == in_rt & ~in_alusrc)) & in_valid. It is combinational.
- hazard_stall is forced to 0 when flush=1. Flush kills the load, so no hazard remains.
- When stall=1, hazard_stall may be asserted, but no bubble is inserted.
- Nothing is visible on the outputs while out_valid=0. Downstream must qualify all outputs with out_valid.

Test Plan:
- Reset: assert rst_n=0 with in_valid=1 driven → after the edge, out_valid=0, data1=0, ALUOp=000, hazard_stall=0.
- Basic load: in_rs_val=5, in_rt_val=7, in_aluop=010, in_alusrc=0, in_valid=1 → next cycle data1=5, data2=7, ALUOp=010, out_valid=1.
- Immediate extension:
  - imm=16'hFFFC, signext=1, alusrc=1 → data2=32'hFFFFFFFC.
  - Same with signext=0 → data2=32'h0000FFFC.
- Forwarding: held rs=3, exmem(rd=3, wr=1, 100), memwb(rd=3, wr=1, 200) → data1=100.
  - Drop exmem_regwrite → data1=200.
  - Held rs=0 with exmem_rd=0, exmem_regwrite=1 → data1=0.
- Load-use: held lw (memread=1, out_rd=4), incoming in_rs=4, in_valid=1 → hazard_stall=1; next edge out_valid=0.
  - The following cycle, with the upstream held, the instruction loads and data1 takes memwb_result when memwb_rd=4.
- Stall then flush:
  - stall=1 for 2 cycles → outputs held while forwarding still tracks a changing exmem_result.
  - flush=1 with stall=1 → next cycle out_valid=0 and out_regwrite=0.
